// File: rtl/sel_clk_divider.sv
`default_nettype none
// ============================================================================
// Module : sel_clk_divider
// Brief  : Selectable power-of-two clock divider, 50% duty, registered output.
//          Define CLKDIV_SEL_SYNC_EN for glitch-free (period-aligned) select.
// Rev    : 1.0 - initial release
// ============================================================================
module sel_clk_divider #(
  parameter int CNT_W = 8
) (
  input  logic       clk_i,
  input  logic       rstn_i,
  input  logic [1:0] sel_i,
  input  logic       en_i,
  output logic       dclk_o
);

  localparam int               c_KW  = $clog2(CNT_W);
  localparam logic [CNT_W-1:0] c_ONE = CNT_W'(1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_dclk;
  logic [1:0]       r_sel;
  logic             r_fresh;

  logic [1:0]       w_sel;
  logic [c_KW-1:0]  w_k;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_tap;

  // Until the first edge after reset the live select is used, so the ratio
  // present while reset deasserts governs the very first period.
  always_comb begin
    w_sel     = r_fresh ? sel_i : r_sel;
    w_k       = c_KW'(CNT_W - 1 - int'(w_sel));
    w_cnt_nxt = r_cnt + c_ONE;
    w_tap     = w_cnt_nxt[w_k];
  end

`ifdef CLKDIV_SEL_SYNC_EN
  logic [CNT_W-1:0] w_mask;
  logic             w_bound;

  always_comb begin
    w_mask  = ((c_ONE << w_k) << 1) - c_ONE;
    w_bound = ((r_cnt & w_mask) == w_mask);
  end

  // Select is only taken at the end of a full output period; the counter
  // restarts so the new ratio begins with a complete low phase.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_cnt   <= '0;
      r_dclk  <= 1'b0;
      r_sel   <= 2'd0;
      r_fresh <= 1'b1;
    end else begin
      r_fresh <= 1'b0;
      if (r_fresh) begin
        r_sel <= sel_i;
      end
      if (en_i) begin
        if (w_bound) begin
          r_cnt  <= '0;
          r_dclk <= 1'b0;
          r_sel  <= sel_i;
        end else begin
          r_cnt  <= w_cnt_nxt;
          r_dclk <= w_tap;
        end
      end
    end
  end
`else
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_cnt   <= '0;
      r_dclk  <= 1'b0;
      r_sel   <= 2'd0;
      r_fresh <= 1'b1;
    end else begin
      r_fresh <= 1'b0;
      r_sel   <= sel_i;
      if (en_i) begin
        r_cnt  <= w_cnt_nxt;
        r_dclk <= w_tap;
      end
    end
  end
`endif

  assign dclk_o = r_dclk;

endmodule
`default_nettype wire

// File: tb/tb_sel_clk_divider.sv
`default_nettype none
// Testbench for sel_clk_divider: directed timing checks plus randomized
// enable/select traffic against a period-arithmetic reference model.
module tb_sel_clk_divider;

  localparam int CNT_W = 8;
  localparam int T     = 10;

  logic       clk    = 1'b0;
  logic       rstn_i = 1'b1;
  logic [1:0] sel_i  = 2'd0;
  logic       en_i   = 1'b0;
  logic       dclk_o;

  int n_cmp = 0;
  int n_mis = 0;

  // Reference model: enabled edges elapsed (mod 2**CNT_W) and effective ratio.
  int     m_cnt;
  int     m_sel;
  bit     m_fresh;
  bit     m_dclk;
  bit     prev_obs;
  longint t_rise;

  sel_clk_divider #(.CNT_W(CNT_W)) dut (
    .clk_i  (clk),
    .rstn_i (rstn_i),
    .sel_i  (sel_i),
    .en_i   (en_i),
    .dclk_o (dclk_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    m_cnt   = 0;
    m_sel   = 0;
    m_fresh = 1'b1;
    m_dclk  = 1'b0;
  endfunction

  // Output is high during the second half of every 2**(k+1)-edge period.
  function automatic void model_edge(input bit en, input int sel);
    int eff  = m_fresh ? sel : m_sel;
    int half = 1 << (CNT_W - 1 - eff);
`ifdef CLKDIV_SEL_SYNC_EN
    if (m_fresh) m_sel = sel;
    if (en) begin
      if ((m_cnt % (2 * half)) == (2 * half - 1)) begin
        m_cnt = 0;
        m_sel = sel;
      end else begin
        m_cnt = (m_cnt + 1) % (1 << CNT_W);
      end
      m_dclk = ((m_cnt / half) % 2) == 1;
    end
`else
    m_sel = sel;
    if (en) begin
      m_cnt  = (m_cnt + 1) % (1 << CNT_W);
      m_dclk = ((m_cnt / half) % 2) == 1;
    end
`endif
    m_fresh = 1'b0;
  endfunction

  // Called at posedge+1; drives inputs, takes one clock, checks output.
  task automatic step(input bit en, input bit [1:0] sel, output bit rose);
    en_i  = en;
    sel_i = sel;
    @(posedge clk);
    model_edge(en, int'(sel));
    #1;
    chk("dclk", {63'd0, dclk_o}, {63'd0, m_dclk});
    rose = !prev_obs && (dclk_o === 1'b1);
    if (rose) t_rise = $time - 1;
    prev_obs = (dclk_o === 1'b1);
  endtask

  task automatic run_to_rise(input int budget, input bit [1:0] sel, output int n);
    bit rose = 1'b0;
    n = 0;
    while (!rose && n < budget) begin
      step(1'b1, sel, rose);
      n++;
    end
    chk("rise_seen", {63'd0, rose}, 64'd1);
  endtask

  // Called at posedge+1; 5-unit low pulse ending before the next edge.
  task automatic do_reset(input bit [1:0] sel);
    rstn_i = 1'b0;
    sel_i  = sel;
    #1;
    chk("async_reset_dclk", {63'd0, dclk_o}, 64'd0);
    model_reset();
    prev_obs = 1'b0;
    #4;
    rstn_i = 1'b1;
  endtask

  initial begin
    longint     t0, t1;
    int         n, h, l;
    bit         r;
    bit [1:0]   cur_sel;

    en_i = 1'b1;
    @(posedge clk);
    #1;
    do_reset(2'd0);

    // Ratio per select: edges to first rise and rise-to-rise period.
    for (int s = 0; s < 4; s++) begin
      do_reset(s[1:0]);
      run_to_rise(600, s[1:0], n);
      chk("first_rise_edges", n, 1 << (CNT_W - 1 - s));
      t0 = t_rise;
      run_to_rise(600, s[1:0], n);
      chk("period", t_rise - t0, (1 << (CNT_W - s)) * T);
    end

    // Asynchronous reset in the middle of a high phase.
    do_reset(2'd2);
    run_to_rise(600, 2'd2, n);
    repeat (10) step(1'b1, 2'd2, r);
    chk("high_before_reset", {63'd0, dclk_o}, 64'd1);
    do_reset(2'd2);
    run_to_rise(600, 2'd2, n);
    chk("rise_after_reset", n, 32);

    // 37-cycle enable freeze in mid-period stretches the period by 37 clocks.
    do_reset(2'd3);
    run_to_rise(600, 2'd3, n);
    t0 = t_rise;
    repeat (5)  step(1'b1, 2'd3, r);
    repeat (37) step(1'b0, 2'd3, r);
    run_to_rise(600, 2'd3, n);
    chk("gap_with_freeze", t_rise - t0, 32 * T + 37 * T);

    // Duty at /32 across 20 periods (includes counter wrap).
    for (int p = 0; p < 20; p++) begin
      h = 0;
      l = 0;
      do begin
        step(1'b1, 2'd3, r);
        h++;
      end while (dclk_o === 1'b1 && h < 100);
      do begin
        step(1'b1, 2'd3, r);
        l++;
      end while (dclk_o !== 1'b1 && l < 100);
      chk("duty_high", h, 16);
      chk("duty_low", l, 16);
    end

    // Random enable and occasional select changes.
    cur_sel = 2'($urandom_range(0, 3));
    do_reset(cur_sel);
    repeat (1500) begin
      if ($urandom_range(0, 63) == 0) cur_sel = 2'($urandom_range(0, 3));
      step($urandom_range(0, 7) != 0, cur_sel, r);
    end

    // Select change 0 -> 3 in the middle of a high phase.
    do_reset(2'd0);
    run_to_rise(600, 2'd0, n);
    t0 = t_rise;
    repeat (40) step(1'b1, 2'd0, r);
    run_to_rise(600, 2'd3, n);
    t1 = t_rise;
    run_to_rise(600, 2'd3, n);
`ifdef CLKDIV_SEL_SYNC_EN
    chk("sel_change_first_gap", t1 - t0, (128 + 16) * T);
`else
    chk("sel_change_first_gap", t1 - t0, 48 * T);
`endif
    chk("sel_change_period", t_rise - t1, 32 * T);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
`default_nettype wire
